prom_access_ctl: RTL and testbench

Sequencer and two-port arbiter for a 32x8 bipolar PROM (5610-type) on the CADR board. It shares one PROM between two requesters, port 0 and port 1. It drives the PROM address and active-low chip enable, and holds CE low for a programmable number of clocks to cover the PROM access delay. It then captures the tri-stated data bus and returns it with a one-cycle acknowledge.

---
 rtl/cadr_prom_pkg.sv | 17 +
 rtl/prom_rr_arb2.sv | 39 +++
 rtl/prom_access_ctl.sv | 108 ++++++++++
 tb/tb_prom_access_ctl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cadr_prom_pkg.sv
// Shared constants and state encoding for the CADR PROM access sequencer.
package cadr_prom_pkg;

    localparam int PROM_ADDR_W = 5;
    localparam int PROM_DATA_W = 8;
    localparam int WAIT_MIN    = 1;
    localparam int WAIT_MAX    = 15;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } prom_state_e;

endpackage

// File: rtl/prom_rr_arb2.sv
// Two-way round-robin arbiter: purely combinational grant, last_grant updates on accept.
// Latency 0 (grant follows req in the same cycle); no backpressure, requests wait at the caller.
// last_grant resets to port 1 so port 0 wins the first tie.
module prom_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        if (req0 && req1) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
        if (accept && (grant != 2'b00)) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/prom_access_ctl.sv
// Shares one 32x8 bipolar PROM between two requesters, sequencing address setup and CE timing.
// Latency: ack WAIT_CYCLES+1 clocks after the request is sampled in IDLE; one access per WAIT_CYCLES+3 clocks.
// Backpressure: requests are levels held until ack; a losing port simply waits in IDLE for its turn.
module prom_access_ctl
    import cadr_prom_pkg::*;
#(
    parameter int ADDR_W      = PROM_ADDR_W,
    parameter int DATA_W      = PROM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] prom_a,
    output logic              prom_ce_n,
    input  logic [DATA_W-1:0] prom_d
);

    if ((WAIT_CYCLES < WAIT_MIN) || (WAIT_CYCLES > WAIT_MAX)) begin : g_bad_wait_cycles
        $error("prom_access_ctl: WAIT_CYCLES must be within 1..15");
    end

    prom_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       prom_a_q, prom_a_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    port_q, port_d;
    logic [1:0]              grant;
    logic                    accept;

    prom_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prom_a_d = prom_a_q;
        rdata_d  = rdata_q;
        port_d   = port_q;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    accept   = 1'b1;
                    port_d   = grant[1];
                    prom_a_d = grant[1] ? addr1 : addr0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // prom_d is only trusted on the edge leaving WAIT; earlier it may still be settling.
                if (cnt_q == '0) begin
                    rdata_d = prom_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prom_a_q <= '0;
            rdata_q  <= '0;
            port_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prom_a_q <= prom_a_d;
            rdata_q  <= rdata_d;
            port_q   <= port_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign prom_ce_n = (state_q != WAIT);
    assign ack0      = (state_q == DONE) && !port_q;
    assign ack1      = (state_q == DONE) &&  port_q;
    assign prom_a    = prom_a_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_prom_access_ctl.sv
// Bench for prom_access_ctl: directed literal checks plus randomized traffic against a cycle-index model.
module tb_prom_access_ctl;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [4:0] addr0, addr1;
    logic       ack0, ack1, busy, prom_ce_n;
    logic [7:0] rdata, prom_d;
    logic [4:0] prom_a;

    logic [7:0] rom [32];

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    // Model: m_t is cycles since the granting edge, -1 when idle.
    int         m_t = -1;
    int         m_port = 0;
    int         m_lg = 1;
    logic [4:0] m_addr = '0;
    logic [4:0] m_prom_a = '0;
    logic [7:0] m_rdata = '0;

    always #25 clk = ~clk;

    prom_access_ctl #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .addr0     (addr0),
        .ack0      (ack0),
        .req1      (req1),
        .addr1     (addr1),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .prom_a    (prom_a),
        .prom_ce_n (prom_ce_n),
        .prom_d    (prom_d)
    );

    // PROM: floats while disabled, word appears 10 ns after enable.
    always @(prom_ce_n or prom_a) begin
        if (prom_ce_n) begin
            prom_d = 'x;
        end else begin
            #10;
            if (!prom_ce_n) prom_d = rom[prom_a];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_t = -1; m_lg = 1; m_rdata = '0; m_prom_a = '0;
        end else if (m_t < 0) begin
            if (req0 || req1) begin
                if (req0 && req1) m_port = (m_lg == 1) ? 0 : 1;
                else              m_port = req0 ? 0 : 1;
                m_lg     = m_port;
                m_addr   = (m_port == 0) ? addr0 : addr1;
                m_prom_a = m_addr;
                m_t      = 0;
            end
        end else begin
            m_t++;
            if (m_t == W + 1)      m_rdata = rom[m_addr];
            else if (m_t == W + 2) m_t = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(busy),      32'(m_t >= 0));
            chk("prom_ce_n", 32'(prom_ce_n), 32'(!(m_t >= 1 && m_t <= W)));
            chk("ack0",      32'(ack0),      32'(m_t == W + 1 && m_port == 0));
            chk("ack1",      32'(ack1),      32'(m_t == W + 1 && m_port == 1));
            chk("prom_a",    32'(prom_a),    32'(m_prom_a));
            chk("rdata",     32'(rdata),     32'(m_rdata));
            chk("rdata_known", 32'($isunknown(rdata)), 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ce_n", 32'(prom_ce_n), 32'd1);
        chk("rst_prom_a", 32'(prom_a), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single port 0 read of 0x13.
        req0 = 1'b1; addr0 = 5'h13;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 0) chk("t1_prom_a", 32'(prom_a), 32'h13);
            if (c == 0) chk("t1_ce_setup", 32'(prom_ce_n), 32'd1);
            if (c == 1 || c == 2) chk("t1_ce_wait", 32'(prom_ce_n), 32'd0);
            chk("t1_ack0", 32'(ack0), 32'(c == 3));
            if (c == 3) begin
                chk("t1_rdata", 32'(rdata), 32'(rom[5'h13]));
                req0 = 1'b0;
            end
        end

        // Tie held continuously: grants alternate starting with port 0.
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; addr0 = 5'h05; addr1 = 5'h1A;
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk);
            chk("t2_ack0", 32'(ack0), 32'(c == 3 || c == 13));
            chk("t2_ack1", 32'(ack1), 32'(c == 8 || c == 18));
            if (c == 3 || c == 13) chk("t2_rdata0", 32'(rdata), 32'(rom[5'h05]));
            if (c == 8 || c == 18) chk("t2_rdata1", 32'(rdata), 32'(rom[5'h1A]));
        end
        req0 = 1'b0; req1 = 1'b0;

        // Address change after grant must be ignored.
        @(negedge clk);
        req0 = 1'b1; addr0 = 5'h01;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) addr0 = 5'h1F;
            if (c == 3) begin
                chk("t3_prom_a", 32'(prom_a), 32'h01);
                chk("t3_rdata", 32'(rdata), 32'(rom[5'h01]));
                chk("t3_ack0", 32'(ack0), 32'd1);
                req0 = 1'b0;
            end
        end

        // Reset mid-access aborts it; port 0 then wins the first tie.
        req0 = 1'b1; addr0 = 5'h0A;
        for (int c = 0; c <= 2; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_ce_n", 32'(prom_ce_n), 32'd1);
        chk("t4_ack", 32'({ack0, ack1}), 32'd0);
        chk("t4_rdata", 32'(rdata), 32'd0);
        reset = 1'b0; req1 = 1'b1; addr1 = 5'h03;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk("t4_tie_ack0", 32'(ack0), 32'(c == 3));
            chk("t4_tie_ack1", 32'(ack1), 32'd0);
        end
        req0 = 1'b0;

        // Randomized traffic, including occasional resets and address churn.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) addr0 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) addr1 = 5'($urandom);
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
